pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 109 ++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg -- valid/ready pipeline stage.
//   SKID=1: two-entry skid stage, in_ready is a registered signal (no
//           combinational path from out_ready to in_ready).
//   SKID=0: single-entry stage, in_ready = empty | out_ready.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      synchronous kill of all held entries
//   in_valid / in_ready / in_data     upstream handshake and payload
//   out_valid / out_ready / out_data  downstream handshake and payload
//   occupancy  number of held entries (0..2)
module pipe_skid_reg #(
  parameter int unsigned     WIDTH   = 64,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit              SKID    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q;
  logic             in_fire, out_fire;

  // SKID=1 uses the registered ready; SKID=0 lets a draining output make room
  // in the same cycle.
  assign in_ready  = SKID ? rdy_q : ((state_q == EMPTY) | out_ready);
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_valid = (state_q != EMPTY);
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign occupancy = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // An out_fire in this cycle is still a delivery; only held data dies.
      state_d = EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (out_fire) begin
            main_d  = RST_VAL;
            state_d = EMPTY;
          end else if (in_fire && SKID) begin
            skid_d  = in_data;
            state_d = FULL;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = RST_VAL;
            state_d = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = RST_VAL;
          skid_d  = RST_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != FULL);
    end
  end

endmodule
